// File: rtl/bit4_adder.sv
// Registered 4-bit ripple-carry adder with carry-in for the calculator datapath.
// Status flags (cout, ovf, zero) are computed only when BIT4ADDER_FLAGS_EN is defined.
module bit4_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] num1,
    input  logic [3:0] num2,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       ovf,
    output logic       zero
);

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [3:0] carry_s;
    logic [3:0] sum_d;
    logic       cout_d;
    logic       ovf_d;
    logic       zero_d;
    logic [3:0] sum_q;
    logic       cout_q;
    logic       ovf_q;
    logic       zero_q;

    // Ripple-carry chain; carry_s[i] is the carry into bit i.
    always_comb begin
        carry_s    = 4'b0000;
        carry_s[0] = cin;
        for (int i = 0; i < 3; i++) begin
            carry_s[i+1] = fa_carry(num1[i], num2[i], carry_s[i]);
        end
        for (int i = 0; i < 4; i++) begin
            sum_d[i] = fa_sum(num1[i], num2[i], carry_s[i]);
        end
`ifdef BIT4ADDER_FLAGS_EN
        cout_d = fa_carry(num1[3], num2[3], carry_s[3]);
        ovf_d  = carry_s[3] ^ cout_d;
        zero_d = (sum_d == 4'h0);
`else
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        zero_d = 1'b0;
`endif
    end

    // Output registers; reset forces every flag low, including zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 4'h0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_bit4_adder.sv
// Self-checking bench for bit4_adder: directed vectors then randomized operands,
// compared against an integer-arithmetic reference model.
module tb_bit4_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] num1 = 4'h0;
    logic [3:0] num2 = 4'h0;
    logic       cin = 1'b0;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;

    int checks = 0;
    int failures = 0;

`ifdef BIT4ADDER_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    bit4_adder dut (
        .clk (clk),
        .rst (rst),
        .num1(num1),
        .num2(num2),
        .cin (cin),
        .sum (sum),
        .cout(cout),
        .ovf (ovf),
        .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one vector, clock it in, and compare the registered outputs.
    task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic r);
        int total;
        int sa;
        int sb;
        int stot;
        logic [3:0] e_sum;
        logic e_cout;
        logic e_ovf;
        logic e_zero;
        num1 = a;
        num2 = b;
        cin  = c;
        rst  = r;
        @(posedge clk);
        #1;
        total = int'(a) + int'(b) + int'(c);
        sa    = (a >= 4'd8) ? int'(a) - 16 : int'(a);
        sb    = (b >= 4'd8) ? int'(b) - 16 : int'(b);
        stot  = sa + sb + int'(c);
        if (r) begin
            e_sum = 4'h0; e_cout = 1'b0; e_ovf = 1'b0; e_zero = 1'b0;
        end else begin
            e_sum  = 4'(total % 16);
            e_cout = FLAGS_ON && (total > 15);
            e_ovf  = FLAGS_ON && ((stot > 7) || (stot < -8));
            e_zero = FLAGS_ON && ((total % 16) == 0);
        end
        check({tag, ".sum"},  sum, e_sum);
        check({tag, ".cout"}, {3'b000, cout}, {3'b000, e_cout});
        check({tag, ".ovf"},  {3'b000, ovf},  {3'b000, e_ovf});
        check({tag, ".zero"}, {3'b000, zero}, {3'b000, e_zero});
    endtask

    initial begin
        apply("reset0", 4'hF, 4'hF, 1'b1, 1'b1);
        apply("reset1", 4'hF, 4'hF, 1'b1, 1'b1);

        apply("v0p0", 4'h0, 4'h0, 1'b0, 1'b0);
        apply("vFpF", 4'hF, 4'hF, 1'b0, 1'b0);
        apply("v9p6", 4'h9, 4'h6, 1'b0, 1'b0);
        apply("v1pF", 4'h1, 4'hF, 1'b0, 1'b0);
        apply("v1p1", 4'h1, 4'h1, 1'b0, 1'b0);
        apply("v5pC", 4'h5, 4'hC, 1'b0, 1'b0);

        apply("ovf7p1", 4'h7, 4'h1, 1'b0, 1'b0);
        apply("ovf8p8", 4'h8, 4'h8, 1'b0, 1'b0);
        apply("ovfFpF", 4'hF, 4'hF, 1'b0, 1'b0);

        apply("cin7p8", 4'h7, 4'h8, 1'b1, 1'b0);
        apply("cin0p0", 4'h0, 4'h0, 1'b1, 1'b0);

        apply("rst3p4", 4'h3, 4'h4, 1'b0, 1'b1);
        apply("rel3p4", 4'h3, 4'h4, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            apply("rand", 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                  1'($urandom_range(1, 0)), ($urandom_range(15, 0) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
